// File: rtl/math_issue_queue.sv
// Collapsing, age-ordered issue queue for the integer execute stage.
// Index 0 holds the oldest op; the oldest fully-ready op is presented for issue each cycle.
module math_issue_queue #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned PRF_W   = 6,
    parameter int unsigned ROB_W   = 6
) (
    input  logic                         cpu_clock_i,
    input  logic                         cpu_reset_ni,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [ROB_W-1:0]             enq_rob_i,
    input  logic [PRF_W-1:0]             enq_rs1_i,
    input  logic [PRF_W-1:0]             enq_rs2_i,
    input  logic                         enq_rs1_rdy_i,
    input  logic                         enq_rs2_rdy_i,
    input  logic [PRF_W-1:0]             wk0_dest_i,
    input  logic                         wk0_valid_i,
    input  logic [PRF_W-1:0]             wk1_dest_i,
    input  logic                         wk1_valid_i,
    output logic [2*PRF_W+ROB_W-1:0]     issue_data_o,
    output logic                         issue_valid_o,
    output logic [$clog2(ENTRIES):0]     count_o
);

    localparam int unsigned CNT_W = $clog2(ENTRIES) + 1;
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] vld_q, vld_d;
    logic [ENTRIES-1:0] rdy1_q, rdy1_d;
    logic [ENTRIES-1:0] rdy2_q, rdy2_d;
    logic [ROB_W-1:0]   rob_q [ENTRIES];
    logic [ROB_W-1:0]   rob_d [ENTRIES];
    logic [PRF_W-1:0]   rs1_q [ENTRIES];
    logic [PRF_W-1:0]   rs1_d [ENTRIES];
    logic [PRF_W-1:0]   rs2_q [ENTRIES];
    logic [PRF_W-1:0]   rs2_d [ENTRIES];
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ENTRIES-1:0] rdy1_w, rdy2_w;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               enq_fire, issue_fire;
    logic               enq_rdy1, enq_rdy2;
    logic [CNT_W-1:0]   wr_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!sel_found && vld_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign enq_ready_o   = (count_q < CNT_W'(ENTRIES));
    assign issue_valid_o = sel_found & ~flush_i;
    assign issue_data_o  = sel_found ? {rs2_q[sel_idx], rs1_q[sel_idx], rob_q[sel_idx]} : '0;
    assign count_o       = count_q;

    assign enq_fire   = enq_valid_i & enq_ready_o & ~flush_i;
    assign issue_fire = issue_valid_o;

    // Same-cycle wakeups are folded into the enqueued ready bits.
    assign enq_rdy1 = enq_rs1_rdy_i | (enq_rs1_i == '0)
                    | (wk0_valid_i && wk0_dest_i == enq_rs1_i)
                    | (wk1_valid_i && wk1_dest_i == enq_rs1_i);
    assign enq_rdy2 = enq_rs2_rdy_i | (enq_rs2_i == '0)
                    | (wk0_valid_i && wk0_dest_i == enq_rs2_i)
                    | (wk1_valid_i && wk1_dest_i == enq_rs2_i);

    always_comb begin
        rdy1_w = rdy1_q;
        rdy2_w = rdy2_q;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if ((wk0_valid_i && wk0_dest_i == rs1_q[i]) || (wk1_valid_i && wk1_dest_i == rs1_q[i]))
                rdy1_w[i] = 1'b1;
            if ((wk0_valid_i && wk0_dest_i == rs2_q[i]) || (wk1_valid_i && wk1_dest_i == rs2_q[i]))
                rdy2_w[i] = 1'b1;
        end
    end

    always_comb begin
        vld_d   = vld_q;
        rdy1_d  = rdy1_w;
        rdy2_d  = rdy2_w;
        rob_d   = rob_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
        wr_idx  = issue_fire ? count_q - CNT_W'(1) : count_q;

        // Entries above the issued slot collapse down by one, keeping their wakeups.
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (issue_fire && IDX_W'(i) >= sel_idx) begin
                automatic int unsigned nxt = (i + 1 < ENTRIES) ? i + 1 : i;
                vld_d[i]  = (i + 1 < ENTRIES) ? vld_q[nxt] : 1'b0;
                rdy1_d[i] = rdy1_w[nxt];
                rdy2_d[i] = rdy2_w[nxt];
                rob_d[i]  = rob_q[nxt];
                rs1_d[i]  = rs1_q[nxt];
                rs2_d[i]  = rs2_q[nxt];
            end
        end

        if (enq_fire) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    vld_d[i]  = 1'b1;
                    rdy1_d[i] = enq_rdy1;
                    rdy2_d[i] = enq_rdy2;
                    rob_d[i]  = enq_rob_i;
                    rs1_d[i]  = enq_rs1_i;
                    rs2_d[i]  = enq_rs2_i;
                end
            end
        end

        if (flush_i) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_ni) begin
            vld_q   <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                rob_q[i] <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            count_q <= count_d;
            rob_q   <= rob_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

endmodule

// File: tb/tb_math_issue_queue.sv
// Directed bench for math_issue_queue: queue-based reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_math_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        enq_v;
    logic        enq_rdy;
    logic [5:0]  enq_rob, enq_rs1, enq_rs2;
    logic        enq_r1, enq_r2;
    logic [5:0]  wk0_d, wk1_d;
    logic        wk0_v, wk1_v;
    logic [17:0] iss_data;
    logic        iss_v;
    logic [3:0]  cnt;

    int n_chk  = 0;
    int n_fail = 0;

    math_issue_queue #(.ENTRIES(8), .PRF_W(6), .ROB_W(6)) dut (
        .cpu_clock_i   (clk),
        .cpu_reset_ni  (rst_n),
        .flush_i       (flush),
        .enq_valid_i   (enq_v),
        .enq_ready_o   (enq_rdy),
        .enq_rob_i     (enq_rob),
        .enq_rs1_i     (enq_rs1),
        .enq_rs2_i     (enq_rs2),
        .enq_rs1_rdy_i (enq_r1),
        .enq_rs2_rdy_i (enq_r2),
        .wk0_dest_i    (wk0_d),
        .wk0_valid_i   (wk0_v),
        .wk1_dest_i    (wk1_d),
        .wk1_valid_i   (wk1_v),
        .issue_data_o  (iss_data),
        .issue_valid_o (iss_v),
        .count_o       (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] rob;
        logic [5:0] rs1;
        logic [5:0] rs2;
        bit         r1;
        bit         r2;
    } ent_t;

    ent_t model_q[$];
    bit   model_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit woken(input logic [5:0] tag);
        return (wk0_v && wk0_d == tag) || (wk1_v && wk1_d == tag);
    endfunction

    // Reference model: compare then advance to the state after the coming edge.
    always @(negedge clk) begin
        int   k;
        bit   e_valid;
        logic [17:0] e_data;
        ent_t e;
        k = -1;
        foreach (model_q[i])
            if (k < 0 && model_q[i].r1 && model_q[i].r2) k = i;
        e_valid = (k >= 0) && !flush;
        e_data  = (k >= 0) ? {model_q[k].rs2, model_q[k].rs1, model_q[k].rob} : 18'h0;
        if (model_ok) begin
            chk("model_issue_valid", 32'(iss_v), 32'(e_valid));
            chk("model_issue_data", 32'(iss_data), 32'(e_data));
            chk("model_enq_ready", 32'(enq_rdy), 32'(model_q.size() < 8));
            chk("model_count", 32'(cnt), 32'(model_q.size()));
        end
        if (!rst_n) begin
            model_q.delete();
            model_ok = 1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            bit fire;
            fire  = enq_v && (model_q.size() < 8);
            e.rob = enq_rob;
            e.rs1 = enq_rs1;
            e.rs2 = enq_rs2;
            e.r1  = enq_r1 || enq_rs1 == 6'd0 || woken(enq_rs1);
            e.r2  = enq_r2 || enq_rs2 == 6'd0 || woken(enq_rs2);
            foreach (model_q[i]) begin
                if (woken(model_q[i].rs1)) model_q[i].r1 = 1;
                if (woken(model_q[i].rs2)) model_q[i].r2 = 1;
            end
            if (e_valid) model_q.delete(k);
            if (fire) model_q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush   = 0;
        enq_v   = 0;
        enq_rob = '0;
        enq_rs1 = '0;
        enq_rs2 = '0;
        enq_r1  = 0;
        enq_r2  = 0;
        wk0_v   = 0;
        wk0_d   = '0;
        wk1_v   = 0;
        wk1_d   = '0;
    endtask

    task automatic enq(input logic [5:0] rob, input logic [5:0] rs1, input logic [5:0] rs2,
                       input logic r1, input logic r2);
        enq_v   = 1;
        enq_rob = rob;
        enq_rs1 = rs1;
        enq_rs2 = rs2;
        enq_r1  = r1;
        enq_r2  = r2;
    endtask

    initial begin
        rst_n = 0;
        idle();
        tick();
        tick();
        rst_n = 1;
        chk("reset_valid", 32'(iss_v), 0);
        chk("reset_ready", 32'(enq_rdy), 1);
        chk("reset_count", 32'(cnt), 0);
        chk("reset_data", 32'(iss_data), 0);

        // Tag 0 sources are ready regardless of the rename ready bits.
        enq(6'd3, 6'd0, 6'd0, 0, 0);
        tick();
        idle();
        chk("t1_valid", 32'(iss_v), 1);
        chk("t1_data", 32'(iss_data), 32'h00003);
        chk("t1_count", 32'(cnt), 1);
        tick();
        chk("t1_drained", 32'(cnt), 0);

        enq(6'd5, 6'd12, 6'd0, 0, 0);
        tick();
        idle();
        chk("t2_wait", 32'(iss_v), 0);
        chk("t2_count", 32'(cnt), 1);
        wk0_v = 1;
        wk0_d = 6'd12;
        #1;
        chk("t2_no_comb_wake", 32'(iss_v), 0);
        tick();
        idle();
        chk("t2_valid", 32'(iss_v), 1);
        chk("t2_data", 32'(iss_data), 32'h00305);
        tick();

        enq(6'd7, 6'd9, 6'd0, 0, 0);
        wk1_v = 1;
        wk1_d = 6'd9;
        tick();
        idle();
        chk("t3_valid", 32'(iss_v), 1);
        chk("t3_data", 32'(iss_data), 32'h00247);
        tick();

        for (int i = 0; i < 8; i++) begin
            enq(6'(8 + i), 6'(16 + i), 6'd0, 0, 0);
            tick();
        end
        idle();
        chk("full_ready", 32'(enq_rdy), 0);
        chk("full_count", 32'(cnt), 8);
        enq(6'd50, 6'd0, 6'd0, 1, 1);
        tick();
        idle();
        chk("full_enq_ignored", 32'(cnt), 8);
        wk0_v = 1;
        wk0_d = 6'd20;
        tick();
        idle();
        chk("mid_valid", 32'(iss_v), 1);
        chk("mid_data", 32'(iss_data), 32'h0050C);
        enq(6'd51, 6'd0, 6'd0, 1, 1);
        tick();
        idle();
        chk("full_issue_no_enq", 32'(cnt), 7);
        chk("ready_after_issue", 32'(enq_rdy), 1);

        wk0_v = 1;
        wk0_d = 6'd16;
        wk1_v = 1;
        wk1_d = 6'd17;
        tick();
        idle();
        chk("dual_wake_first", 32'(iss_data), 32'h00408);
        tick();
        chk("dual_wake_second", 32'(iss_data), 32'h00449);
        tick();
        chk("after_dual_count", 32'(cnt), 5);

        wk0_v = 1;
        wk0_d = 6'd23;
        tick();
        idle();
        chk("tail_data", 32'(iss_data), 32'h005CF);
        enq(6'd52, 6'd0, 6'd24, 0, 0);
        tick();
        idle();
        chk("issue_enq_count", 32'(cnt), 5);
        wk1_v = 1;
        wk1_d = 6'd24;
        tick();
        idle();
        chk("rs2_wake_valid", 32'(iss_v), 1);
        chk("rs2_wake_data", 32'(iss_data), 32'h18034);
        tick();
        chk("rs2_wake_count", 32'(cnt), 4);

        enq(6'd53, 6'd25, 6'd0, 0, 0);
        tick();
        idle();
        chk("pre_flush_count", 32'(cnt), 5);
        wk0_v = 1;
        wk0_d = 6'd18;
        tick();
        idle();
        chk("pre_flush_data", 32'(iss_data), 32'h0048A);
        flush = 1;
        enq(6'd40, 6'd0, 6'd0, 1, 1);
        #1;
        chk("flush_blocks_issue", 32'(iss_v), 0);
        tick();
        idle();
        chk("flush_count", 32'(cnt), 0);
        chk("flush_valid", 32'(iss_v), 0);
        tick();
        chk("flush_enq_dropped", 32'(cnt), 0);

        enq(6'd1, 6'd0, 6'd0, 0, 0);
        tick();
        enq(6'd2, 6'd0, 6'd0, 0, 0);
        chk("order_first", 32'(iss_data), 32'h00001);
        tick();
        idle();
        chk("order_second", 32'(iss_data), 32'h00002);
        tick();
        chk("order_count", 32'(cnt), 0);

        enq(6'd60, 6'd33, 6'd0, 0, 0);
        tick();
        enq(6'd61, 6'd0, 6'd0, 1, 1);
        tick();
        idle();
        chk("pre_reset_count", 32'(cnt), 2);
        rst_n = 0;
        enq(6'd62, 6'd0, 6'd0, 1, 1);
        tick();
        rst_n = 1;
        idle();
        chk("rst2_valid", 32'(iss_v), 0);
        chk("rst2_ready", 32'(enq_rdy), 1);
        chk("rst2_count", 32'(cnt), 0);
        chk("rst2_data", 32'(iss_data), 0);
        tick();
        chk("rst2_stays_empty", 32'(cnt), 0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
